// File: rtl/gf2_rref_sched_pkg.sv
// Shared types and width helpers for the gf2_rref scheduler slice.
package gf2_rref_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RESP,
        FAULT
    } sched_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gf2_rref_sched_if.sv
// Request/response bus between the requesters, the scheduler and the result consumer.
interface gf2_rref_sched_if
    import gf2_rref_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ROWS = 8,
    parameter int COLS = 9
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]                      req_valid;
    logic [NREQ-1:0]                      req_ready;
    logic [NREQ-1:0][ROWS-1:0][COLS-1:0]  req_aug;
    logic                                 rsp_valid;
    logic                                 rsp_ready;
    logic [IDW-1:0]                       rsp_id;
    logic [ROWS-1:0][COLS-1:0]            rsp_rref;
    logic                                 rsp_err;

    modport slave (
        input  req_valid, req_aug, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rref, rsp_err
    );

    modport master (
        output req_valid, req_aug, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rref, rsp_err
    );

endinterface

// File: rtl/gf2_rref_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            valid_o
);
    logic [IDW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[idx]) begin
                valid_o      = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/gf2_rref_sched.sv
// Round-robin scheduler sharing one gf2_rref engine between NREQ requesters,
// with a watchdog that turns a hung engine into a sticky fault.
module gf2_rref_sched
    import gf2_rref_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int ROWS        = 8,
    parameter int COLS        = 9,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gf2_rref_sched_if.slave           bus,
    output logic                      eng_start_o,
    output logic [ROWS-1:0][COLS-1:0] eng_aug_o,
    input  logic                      eng_ready_i,
    input  logic [ROWS-1:0][COLS-1:0] eng_rref_i,
    output logic                      busy_o,
    output logic                      fault_o,
    output logic [15:0]               jobs_done_o
);
    localparam int IDW = id_width(NREQ);
    localparam int WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    sched_state_e              state_q;
    logic [IDW-1:0]            ptr_q;
    logic [IDW-1:0]            rsp_id_q;
    logic [IDW-1:0]            grant_idx;
    logic [NREQ-1:0]           grant;
    logic                      grant_valid;
    logic [ROWS-1:0][COLS-1:0] job_q;
    logic [ROWS-1:0][COLS-1:0] rsp_rref_q;
    logic                      rsp_valid_q;
    logic                      rsp_err_q;
    logic                      eng_start_q;
    logic                      fault_q;
    logic [WDW-1:0]            wdog_q;
    logic [WDW-1:0]            wdog_d;
    logic [15:0]               jobs_done_q;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i       (bus.req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .valid_o     (grant_valid)
    );

    assign wdog_d = wdog_q + WDW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            rsp_id_q    <= '0;
            job_q       <= '0;
            rsp_rref_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            eng_start_q <= 1'b0;
            fault_q     <= 1'b0;
            wdog_q      <= '0;
            jobs_done_q <= '0;
        end else begin
            eng_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_valid && !fault_q) begin
                        job_q       <= bus.req_aug[grant_idx];
                        rsp_id_q    <= grant_idx;
                        ptr_q       <= grant_idx;
                        eng_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                // A ready pulse wins over expiry when both land in the same cycle.
                WAIT: begin
                    wdog_q <= wdog_d;
                    if (eng_ready_i) begin
                        rsp_rref_q  <= eng_rref_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
                        rsp_rref_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        fault_q     <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (!rsp_err_q) begin
                            jobs_done_q <= jobs_done_q + 16'd1;
                        end
                        state_q <= fault_q ? FAULT : IDLE;
                    end
                end
                FAULT: state_q <= FAULT;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is only visible outside reset so a request can never be lost to a reset edge.
    assign bus.req_ready = (rst_n && state_q == IDLE && !fault_q) ? grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rref  = rsp_rref_q;
    assign bus.rsp_err   = rsp_err_q;
    assign eng_start_o   = eng_start_q;
    assign eng_aug_o     = job_q;
    assign busy_o        = (state_q != IDLE);
    assign fault_o       = fault_q;
    assign jobs_done_o   = jobs_done_q;

endmodule

// File: tb/tb_gf2_rref_sched.sv
// Self-checking bench for gf2_rref_sched with a behavioural GF(2) elimination engine
// stub and a response scoreboard.
module tb_gf2_rref_sched;
    import gf2_rref_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int WDOG = 16;
    localparam int IDW  = id_width(NREQ);

    typedef logic [ROWS-1:0][COLS-1:0] mat_t;
    typedef struct packed {
        logic [IDW-1:0] id;
        mat_t           rref;
        logic           err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eng_start;
    logic        eng_ready;
    logic        busy;
    logic        fault;
    mat_t        eng_aug;
    mat_t        eng_rref;
    logic [15:0] jobs_done;

    gf2_rref_sched_if #(.NREQ(NREQ), .ROWS(ROWS), .COLS(COLS)) bus ();

    gf2_rref_sched #(.NREQ(NREQ), .ROWS(ROWS), .COLS(COLS), .WDOG_CYCLES(WDOG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .eng_start_o (eng_start),
        .eng_aug_o   (eng_aug),
        .eng_ready_i (eng_ready),
        .eng_rref_i  (eng_rref),
        .busy_o      (busy),
        .fault_o     (fault),
        .jobs_done_o (jobs_done)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   passed = 0;
    rsp_t sb[$];

    logic engReadyModel = 1'b0;
    logic spuriousReady = 1'b0;
    mat_t engRrefModel = '0;
    int   engCnt = 0;
    int   engLatency = 3;
    bit   engHang = 1'b0;

    // Reduce the A part (all columns but the last) to row-echelon form over GF(2).
    function automatic mat_t rref(input mat_t a);
        mat_t            m;
        logic [COLS-1:0] t;
        int              r;
        int              p;
        m = a;
        r = 0;
        for (int c = COLS - 1; c >= 1; c--) begin
            p = -1;
            for (int i = r; i < ROWS; i++) if (p < 0 && m[i][c]) p = i;
            if (p >= 0) begin
                t = m[r]; m[r] = m[p]; m[p] = t;
                for (int i = 0; i < ROWS; i++) if (i != r && m[i][c]) m[i] = m[i] ^ m[r];
                r++;
            end
        end
        return m;
    endfunction

    function automatic mat_t mk3(input logic [COLS-1:0] r0, input logic [COLS-1:0] r1,
                                 input logic [COLS-1:0] r2);
        mat_t m;
        m[0] = r0; m[1] = r1; m[2] = r2;
        return m;
    endfunction

    function automatic rsp_t mkRsp(input int id, input mat_t m, input logic err);
        rsp_t r;
        r.id = IDW'(id); r.rref = m; r.err = err;
        return r;
    endfunction

    // Engine stub: answers a start pulse after engLatency cycles unless told to hang.
    assign eng_ready = engReadyModel | spuriousReady;
    assign eng_rref  = engRrefModel;

    always @(posedge clk) begin
        engReadyModel <= 1'b0;
        if (!rst_n) begin
            engCnt <= 0;
        end else if (eng_start && !engHang) begin
            engCnt <= engLatency;
        end else if (engCnt > 0) begin
            engCnt <= engCnt - 1;
            if (engCnt == 1) begin
                engReadyModel <= 1'b1;
                engRrefModel  <= rref(eng_aug);
            end
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_aug = '0; bus.rsp_ready = 1'b0;
        spuriousReady = 1'b0; engHang = 1'b0; engLatency = 3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic collect_rsp(output rsp_t got, output bit timedOut);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        timedOut = (n >= 200);
        got.id = bus.rsp_id; got.rref = bus.rsp_rref; got.err = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1; bus.req_aug = '1; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.req_ready !== '0) $display("[TB] FAIL reset_req_ready: got %b want 0", bus.req_ready); else passed++;
        total++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b00) $display("[TB] FAIL reset_rsp_flags: got %b want 00", {bus.rsp_valid, bus.rsp_err}); else passed++;
        total++; if (bus.rsp_id !== '0) $display("[TB] FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); else passed++;
        total++; if (bus.rsp_rref !== '0) $display("[TB] FAIL reset_rsp_rref: got %h want 0", bus.rsp_rref); else passed++;
        total++; if (eng_start !== 1'b0) $display("[TB] FAIL reset_eng_start: got %b want 0", eng_start); else passed++;
        total++; if (eng_aug !== '0) $display("[TB] FAIL reset_eng_aug: got %h want 0", eng_aug); else passed++;
        total++; if ({busy, fault} !== 2'b00) $display("[TB] FAIL reset_busy_fault: got %b want 00", {busy, fault}); else passed++;
        total++; if (jobs_done !== 16'd0) $display("[TB] FAIL reset_jobs_done: got %0d want 0", jobs_done); else passed++;
        bus.req_valid = '0; bus.req_aug = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_job();
        mat_t a, e;
        rsp_t got, exp;
        bit   to;
        a = mk3(4'b1100, 4'b0110, 4'b0011);
        e = mk3(4'b1001, 4'b0101, 4'b0011);
        sb.push_back(mkRsp(2, e, 1'b0));
        bus.req_aug[2] = a; bus.req_valid[2] = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0100) $display("[TB] FAIL single_grant: got %b want 0100", bus.req_ready); else passed++;
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        total++; if (eng_start !== 1'b1) $display("[TB] FAIL single_start_latency: got %b want 1", eng_start); else passed++;
        total++; if (bus.req_ready !== '0) $display("[TB] FAIL single_grant_once: got %b want 0", bus.req_ready); else passed++;
        total++; if (eng_aug !== a) $display("[TB] FAIL single_eng_aug: got %h want %h", eng_aug, a); else passed++;
        @(negedge clk);
        total++; if (eng_start !== 1'b0) $display("[TB] FAIL single_start_pulse: got %b want 0", eng_start); else passed++;
        collect_rsp(got, to);
        exp = sb.pop_front();
        total++; if (to) $display("[TB] FAIL single_rsp_timeout: got no rsp_valid want rsp_valid"); else passed++;
        total++; if (got !== exp) $display("[TB] FAIL single_rsp: got id=%0d rref=%h err=%b want id=%0d rref=%h err=%b", got.id, got.rref, got.err, exp.id, exp.rref, exp.err); else passed++;
        total++; if (jobs_done !== 16'd1) $display("[TB] FAIL single_jobs_done: got %0d want 1", jobs_done); else passed++;
    endtask

    task automatic test_spurious_ready();
        logic [15:0] j0;
        bit          quiet;
        j0 = jobs_done;
        quiet = 1'b1;
        spuriousReady = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        spuriousReady = 1'b0;
        total++; if (!quiet) $display("[TB] FAIL spurious_ready_idle: got rsp_valid/busy asserted want both 0"); else passed++;
        total++; if (jobs_done !== j0) $display("[TB] FAIL spurious_jobs_done: got %0d want %0d", jobs_done, j0); else passed++;
    endtask

    // All requesters held high from a fresh reset: grants must rotate 0,1,2,3,...
    task automatic test_fairness();
        rsp_t got, exp;
        bit   to;
        reset_dut();
        for (int i = 0; i < NREQ; i++) bus.req_aug[i] = mat_t'($urandom);
        for (int j = 0; j < 8; j++) sb.push_back(mkRsp(j % NREQ, rref(bus.req_aug[j % NREQ]), 1'b0));
        bus.req_valid = '1;
        for (int j = 0; j < 8; j++) begin
            collect_rsp(got, to);
            exp = sb.pop_front();
            total++; if (to || got !== exp) $display("[TB] FAIL fair_rsp_%0d: got id=%0d rref=%h err=%b timeout=%b want id=%0d rref=%h err=0", j, got.id, got.rref, got.err, to, exp.id, exp.rref); else passed++;
            if (j == 7) begin
                bus.req_valid = '0;
            end else begin
                total++; if (bus.req_ready !== 4'(1 << ((j + 1) % NREQ))) $display("[TB] FAIL b2b_grant_%0d: got %b want %b", j, bus.req_ready, 4'(1 << ((j + 1) % NREQ))); else passed++;
            end
        end
        total++; if (jobs_done !== 16'd8) $display("[TB] FAIL fair_jobs_done: got %0d want 8", jobs_done); else passed++;
    endtask

    task automatic test_backpressure();
        mat_t        a, b;
        rsp_t        held, exp, got;
        logic [15:0] j0;
        bit          stable, heldOff, countStable, to;
        int          n;
        a = mat_t'($urandom); b = mat_t'($urandom);
        sb.push_back(mkRsp(1, rref(a), 1'b0));
        bus.req_aug[1] = a; bus.req_valid[1] = 1'b1;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        sb.push_back(mkRsp(3, rref(b), 1'b0));
        bus.req_aug[3] = b; bus.req_valid[3] = 1'b1;
        heldOff = 1'b1; stable = 1'b1; countStable = 1'b1; n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            if (bus.req_ready !== '0) heldOff = 1'b0;
            @(negedge clk);
            n++;
        end
        total++; if (bus.rsp_valid !== 1'b1) $display("[TB] FAIL bp_rsp_timeout: got rsp_valid=%b want 1", bus.rsp_valid); else passed++;
        held = {bus.rsp_id, bus.rsp_rref, bus.rsp_err};
        j0 = jobs_done;
        repeat (20) begin
            @(negedge clk);
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_rref, bus.rsp_err} !== {1'b1, held}) stable = 1'b0;
            if (bus.req_ready !== '0) heldOff = 1'b0;
            if (jobs_done !== j0) countStable = 1'b0;
        end
        exp = sb.pop_front();
        total++; if (held !== exp) $display("[TB] FAIL bp_rsp: got id=%0d rref=%h err=%b want id=%0d rref=%h err=%b", held.id, held.rref, held.err, exp.id, exp.rref, exp.err); else passed++;
        total++; if (!stable) $display("[TB] FAIL bp_rsp_stable: got rsp_* changing under backpressure want stable"); else passed++;
        total++; if (!heldOff) $display("[TB] FAIL bp_req_ready_held: got req_ready asserted while busy want 0"); else passed++;
        total++; if (!countStable) $display("[TB] FAIL bp_jobs_before: got jobs_done changing want %0d", j0); else passed++;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        total++; if (jobs_done !== j0 + 16'd1) $display("[TB] FAIL bp_jobs_after: got %0d want %0d", jobs_done, j0 + 16'd1); else passed++;
        total++; if (bus.req_ready !== 4'b1000) $display("[TB] FAIL bp_held_request_granted: got %b want 1000", bus.req_ready); else passed++;
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        collect_rsp(got, to);
        exp = sb.pop_front();
        total++; if (to || got !== exp) $display("[TB] FAIL bp_second_rsp: got id=%0d rref=%h err=%b timeout=%b want id=%0d rref=%h err=0", got.id, got.rref, got.err, to, exp.id, exp.rref); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        mat_t e;
        rsp_t got, exp;
        bit   to, noRsp;
        engLatency = 10;
        bus.req_aug[1] = mat_t'($urandom); bus.req_valid[1] = 1'b1;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({busy, fault, eng_start} !== 3'b000) $display("[TB] FAIL rst_wait_ctrl: got busy/fault/start=%b want 000", {busy, fault, eng_start}); else passed++;
        total++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id} !== '0) $display("[TB] FAIL rst_wait_rsp: got valid/err/id=%b want 0", {bus.rsp_valid, bus.rsp_err, bus.rsp_id}); else passed++;
        total++; if (bus.rsp_rref !== '0 || eng_aug !== '0) $display("[TB] FAIL rst_wait_data: got rsp_rref=%h eng_aug=%h want 0", bus.rsp_rref, eng_aug); else passed++;
        total++; if (jobs_done !== 16'd0) $display("[TB] FAIL rst_wait_jobs: got %0d want 0", jobs_done); else passed++;
        rst_n = 1'b1;
        engLatency = 3;
        noRsp = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) noRsp = 1'b0;
        end
        total++; if (!noRsp) $display("[TB] FAIL rst_wait_discard: got rsp_valid for discarded job want none"); else passed++;
        e = mk3(4'b1000, 4'b0100, 4'b0010);
        sb.push_back(mkRsp(0, e, 1'b0));
        bus.req_aug[0] = e; bus.req_valid[0] = 1'b1;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        collect_rsp(got, to);
        exp = sb.pop_front();
        total++; if (to || got !== exp) $display("[TB] FAIL rst_identity_rsp: got id=%0d rref=%h err=%b timeout=%b want id=%0d rref=%h err=0", got.id, got.rref, got.err, to, exp.id, exp.rref); else passed++;
        total++; if (jobs_done !== 16'd1) $display("[TB] FAIL rst_identity_jobs: got %0d want 1", jobs_done); else passed++;
    endtask

    // Hung engine: WDOG waiting cycles after the start pulse, then an error response.
    task automatic test_watchdog();
        rsp_t        got, exp;
        logic [15:0] j0;
        bit          to, locked;
        int          n;
        engHang = 1'b1;
        sb.push_back(mkRsp(0, '0, 1'b1));
        bus.req_aug[0] = mat_t'($urandom) | mat_t'(1); bus.req_valid[0] = 1'b1;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        total++; if (eng_start !== 1'b1) $display("[TB] FAIL wd_start: got %b want 1", eng_start); else passed++;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== WDOG + 1) $display("[TB] FAIL wd_latency: got %0d cycles want %0d", n, WDOG + 1); else passed++;
        total++; if (fault !== 1'b1) $display("[TB] FAIL wd_fault: got %b want 1", fault); else passed++;
        j0 = jobs_done;
        collect_rsp(got, to);
        exp = sb.pop_front();
        total++; if (to || got !== exp) $display("[TB] FAIL wd_rsp: got id=%0d rref=%h err=%b want id=%0d rref=%h err=%b", got.id, got.rref, got.err, exp.id, exp.rref, exp.err); else passed++;
        total++; if (jobs_done !== j0) $display("[TB] FAIL wd_jobs_done: got %0d want %0d", jobs_done, j0); else passed++;
        bus.req_valid = '1;
        locked = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || eng_start !== 1'b0 || busy !== 1'b1 || fault !== 1'b1) locked = 1'b0;
        end
        bus.req_valid = '0;
        total++; if (!locked) $display("[TB] FAIL wd_fault_terminal: got activity after fault want req_ready=0 rsp_valid=0 busy=1"); else passed++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish want finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        bus.req_valid = '0; bus.req_aug = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_single_job();
        test_spurious_ready();
        test_fairness();
        test_backpressure();
        test_reset_mid_wait();
        test_watchdog();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
